pipelined_mac_stream: RTL and testbench

Parametrised 3-stage pipelined multiply-accumulate engine with full ready/valid flow control on both sides.
- Each accepted beat computes either a*b+c or a running-accumulate a*b+acc.
- Widths and signedness are set by parameter; an optional macro adds saturation.
- Sits in the datapath examples next to the other streaming arithmetic blocks.
- Unlike the earlier fixed 8-bit unit: sustains 1 beat/cycle, stalls losslessly under backpressure, and needs no duplicate-output filtering.

---
 rtl/pipelined_mac_stream_if.sv | 29 ++
 rtl/pipelined_mac_stream.sv | 137 +++++++++++++
 tb/tb_pipelined_mac_stream.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_mac_stream_if.sv
// Ready/valid stream bundle for pipelined_mac_stream: operand beat in, result beat out.
// master drives operands and out_ready; slave is the MAC engine.
interface pipelined_mac_stream_if #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int C_W   = 16,
    parameter int OUT_W = 16
);
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic [C_W-1:0]   in_c;
    logic             in_acc;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_a, in_b, in_c, in_acc, in_valid, out_ready,
        input  in_ready, out_data, out_sat, out_valid
    );

    modport slave (
        input  in_a, in_b, in_c, in_acc, in_valid, out_ready,
        output in_ready, out_data, out_sat, out_valid
    );
endinterface

// File: rtl/pipelined_mac_stream.sv
// 3-stage pipelined multiply-accumulate (a*b+c or a*b+acc) with ready/valid on both sides.
// Optional macro MAC_SAT_EN clamps the sum to the OUT_W range instead of wrapping.
module pipelined_mac_stream #(
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter int C_W    = 16,
    parameter int OUT_W  = 16,
    parameter int SIGNED = 0
) (
    input logic                   clk,
    input logic                   reset,
    pipelined_mac_stream_if.slave bus
);
    localparam int P_W = A_W + B_W;
    localparam bit IS_SIGNED = (SIGNED != 32'sd0);

    generate
        if ((OUT_W < P_W) || (OUT_W < C_W)) begin : g_bad_width
            $error("pipelined_mac_stream: OUT_W must be >= A_W+B_W and >= C_W");
        end
    endgenerate

    logic             en_s;
    logic             s1_v_r, s1_acc_r;
    logic [A_W-1:0]   s1_a_r;
    logic [B_W-1:0]   s1_b_r;
    logic [C_W-1:0]   s1_c_r;
    logic             s2_v_r, s2_acc_r;
    logic [P_W-1:0]   s2_prod_r;
    logic [C_W-1:0]   s2_c_r;
    logic [OUT_W-1:0] acc_r, data_r;
    logic             valid_r;
    logic [P_W-1:0]   a_ext_s, b_ext_s, prod_s;
    logic [OUT_W:0]   p_ext_s, add_ext_s, sum_s;
    logic [OUT_W-1:0] res_s;

    // The whole pipeline advances together whenever the output slot can be vacated.
    assign en_s         = !valid_r || bus.out_ready;
    assign bus.in_ready = en_s;
    assign bus.out_data = data_r;
    assign bus.out_valid = valid_r;

    // Product at full width: operands extended to P_W so the low P_W bits are exact.
    always_comb begin
        a_ext_s = {{B_W{IS_SIGNED & s1_a_r[A_W-1]}}, s1_a_r};
        b_ext_s = {{A_W{IS_SIGNED & s1_b_r[B_W-1]}}, s1_b_r};
        prod_s  = a_ext_s * b_ext_s;
    end

    // Addend selection and one-bit-wider sum so overflow is visible in the top bit.
    always_comb begin
        p_ext_s = {{(OUT_W+1-P_W){IS_SIGNED & s2_prod_r[P_W-1]}}, s2_prod_r};
        if (s2_acc_r) begin
            add_ext_s = {IS_SIGNED & acc_r[OUT_W-1], acc_r};
        end else begin
            add_ext_s = {{(OUT_W+1-C_W){IS_SIGNED & s2_c_r[C_W-1]}}, s2_c_r};
        end
        sum_s = p_ext_s + add_ext_s;
    end

`ifdef MAC_SAT_EN
    logic sat_s, sat_r;

    // Clamp: unsigned overflows only upward; signed overflows when the two top bits differ.
    always_comb begin
        sat_s = 1'b0;
        res_s = sum_s[OUT_W-1:0];
        if (IS_SIGNED) begin
            if (sum_s[OUT_W] != sum_s[OUT_W-1]) begin
                sat_s = 1'b1;
                res_s = sum_s[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                res_s = sum_s[OUT_W-1:0];
            end
        end else begin
            if (sum_s[OUT_W]) begin
                sat_s = 1'b1;
                res_s = {OUT_W{1'b1}};
            end else begin
                res_s = sum_s[OUT_W-1:0];
            end
        end
    end

    // Saturation flag travels with out_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_r <= 1'b0;
        end else if (en_s) begin
            sat_r <= sat_s;
        end
    end

    assign bus.out_sat = sat_r;
`else
    // Plain modulo-2^OUT_W wrap.
    always_comb begin
        res_s = sum_s[OUT_W-1:0];
    end

    assign bus.out_sat = 1'b0;
`endif

    // Pipeline registers; every stage holds while stalled so no beat is lost or repeated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v_r    <= 1'b0;
            s1_acc_r  <= 1'b0;
            s1_a_r    <= {A_W{1'b0}};
            s1_b_r    <= {B_W{1'b0}};
            s1_c_r    <= {C_W{1'b0}};
            s2_v_r    <= 1'b0;
            s2_acc_r  <= 1'b0;
            s2_prod_r <= {P_W{1'b0}};
            s2_c_r    <= {C_W{1'b0}};
            acc_r     <= {OUT_W{1'b0}};
            data_r    <= {OUT_W{1'b0}};
            valid_r   <= 1'b0;
        end else if (en_s) begin
            s1_v_r    <= bus.in_valid;
            s1_acc_r  <= bus.in_acc;
            s1_a_r    <= bus.in_a;
            s1_b_r    <= bus.in_b;
            s1_c_r    <= bus.in_c;
            s2_v_r    <= s1_v_r;
            s2_acc_r  <= s1_acc_r;
            s2_prod_r <= prod_s;
            s2_c_r    <= s1_c_r;
            data_r    <= res_s;
            valid_r   <= s2_v_r;
            // Bubbles leave the accumulator untouched.
            if (s2_v_r) begin
                acc_r <= res_s;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_mac_stream.sv
// Directed bench for pipelined_mac_stream: unsigned instance for streaming, backpressure,
// accumulate and reset cases; signed instance for two's-complement product and overflow.
module tb_pipelined_mac_stream;
    logic clk;
    logic rst;

    pipelined_mac_stream_if u_if ();
    pipelined_mac_stream_if s_if ();

    pipelined_mac_stream dut_u (.clk(clk), .reset(rst), .bus(u_if));
    pipelined_mac_stream #(.SIGNED(1)) dut_s (.clk(clk), .reset(rst), .bus(s_if));

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] c;
        logic        acc;
        logic [15:0] exp_d;
        logic        exp_s;
    } vec_t;

    vec_t vecs[14];
    int vec_cnt = 0;
    int err_cnt = 0;
    int stall_cnt = 0;
    int cyc = 0;
    logic [15:0] got_d[$];
    logic        got_s[$];
    int          got_c[$];
    logic [15:0] sgot_d[$];
    logic        sgot_s[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output transfer (sampled mid-cycle, committed at the next rising edge).
    always @(negedge clk) begin
        if (!rst && u_if.out_valid && u_if.out_ready) begin
            got_d.push_back(u_if.out_data);
            got_s.push_back(u_if.out_sat);
            got_c.push_back(cyc);
        end
        if (!rst && s_if.out_valid && s_if.out_ready) begin
            sgot_d.push_back(s_if.out_data);
            sgot_s.push_back(s_if.out_sat);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c, input logic acc);
        int waits;
        u_if.in_a = a;
        u_if.in_b = b;
        u_if.in_c = c;
        u_if.in_acc = acc;
        u_if.in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!u_if.in_ready && waits < 100) begin
            waits++;
            stall_cnt++;
            @(negedge clk);
        end
        if (!u_if.in_ready) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL push_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
    endtask

    task automatic push_s(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c, input logic acc);
        s_if.in_a = a;
        s_if.in_b = b;
        s_if.in_c = c;
        s_if.in_acc = acc;
        s_if.in_valid = 1'b1;
        @(negedge clk);
        check("s_in_ready", 32'(s_if.in_ready), 32'd1);
        @(posedge clk);
        #1;
        s_if.in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input string name);
        int t;
        t = 0;
        while (got_d.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (got_d.size() < n) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL %s_timeout: got %0d results expected %0d", name, got_d.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{8'(i), 8'(i + 1), 16'(i), 1'b0, 16'(i * (i + 1) + i), 1'b0};
        end
        vecs[8]  = '{8'd2, 8'd3, 16'd10, 1'b0, 16'd16, 1'b0};
        vecs[9]  = '{8'd4, 8'd5, 16'hAAAA, 1'b1, 16'd36, 1'b0};
        vecs[10] = '{8'd1, 8'd1, 16'h5555, 1'b1, 16'd37, 1'b0};
        vecs[11] = '{8'd0, 8'd0, 16'd7, 1'b0, 16'd7, 1'b0};
`ifdef MAC_SAT_EN
        vecs[12] = '{8'd255, 8'd255, 16'd65535, 1'b0, 16'd65535, 1'b1};
        vecs[13] = '{8'd1, 8'd1, 16'h1234, 1'b1, 16'd65535, 1'b1};
`else
        vecs[12] = '{8'd255, 8'd255, 16'd65535, 1'b0, 16'd65024, 1'b0};
        vecs[13] = '{8'd1, 8'd1, 16'h1234, 1'b1, 16'd65025, 1'b0};
`endif

        rst = 1'b1;
        u_if.in_a = 8'd0; u_if.in_b = 8'd0; u_if.in_c = 16'd0; u_if.in_acc = 1'b0;
        u_if.in_valid = 1'b0; u_if.out_ready = 1'b0;
        s_if.in_a = 8'd0; s_if.in_b = 8'd0; s_if.in_c = 16'd0; s_if.in_acc = 1'b0;
        s_if.in_valid = 1'b0; s_if.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
        check("rst_out_data", 32'(u_if.out_data), 32'd0);
        check("rst_out_sat", 32'(u_if.out_sat), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(u_if.in_ready), 32'd1);
        @(posedge clk);
        #1;
        u_if.out_ready = 1'b1;

        // Single beat latency: visible after the second edge following acceptance, for one cycle
        u_if.in_a = 8'd3; u_if.in_b = 8'd4; u_if.in_c = 16'd5; u_if.in_acc = 1'b0;
        u_if.in_valid = 1'b1;
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        check("lat_e0_valid", 32'(u_if.out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_e1_valid", 32'(u_if.out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_e2_valid", 32'(u_if.out_valid), 32'd1);
        check("lat_e2_data", 32'(u_if.out_data), 32'd17);
        @(posedge clk); #1;
        check("lat_e3_valid", 32'(u_if.out_valid), 32'd0);
        got_d.delete(); got_s.delete(); got_c.delete();

        // Table stream: back-to-back beats, accumulate chain, overflow
        stall_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            push(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].acc);
        end
        check("stream_no_stall", 32'(stall_cnt), 32'd0);
        wait_results(14, "stream");
        for (int i = 0; i < 14; i++) begin
            check($sformatf("vec%0d_data", i), 32'((i < got_d.size()) ? got_d[i] : 16'hDEAD), 32'(vecs[i].exp_d));
            check($sformatf("vec%0d_sat", i), 32'((i < got_s.size()) ? got_s[i] : 1'bx), 32'(vecs[i].exp_s));
        end
        for (int i = 1; i < 8; i++) begin
            check($sformatf("consec%0d", i), 32'((i < got_c.size()) ? got_c[i] - got_c[0] : -1), 32'(i));
        end
        got_d.delete(); got_s.delete(); got_c.delete();

        // Backpressure: hold the first result for 4 cycles
        fork
            begin : bp_drive
                for (int i = 0; i < 5; i++) begin
                    push(8'(i + 1), 8'd2, 16'd1, 1'b0);
                end
            end
            begin : bp_ctrl
                int t;
                t = 0;
                while (!u_if.out_valid && t < 100) begin
                    @(posedge clk); #1;
                    t++;
                end
                u_if.out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("bp_hold_data", 32'(u_if.out_data), 32'd3);
                    check("bp_hold_valid", 32'(u_if.out_valid), 32'd1);
                    check("bp_in_ready", 32'(u_if.in_ready), 32'd0);
                end
                @(posedge clk); #1;
                u_if.out_ready = 1'b1;
            end
        join
        wait_results(5, "bp");
        repeat (6) @(posedge clk);
        #1;
        check("bp_count", 32'(got_d.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_data", i), 32'((i < got_d.size()) ? got_d[i] : 16'hDEAD), 32'(2 * i + 3));
        end
        got_d.delete(); got_s.delete(); got_c.delete();

        // Reset mid-flight with accumulator at 50
        push(8'd5, 8'd10, 16'd0, 1'b0);
        wait_results(1, "seed");
        check("seed_data", 32'((got_d.size() > 0) ? got_d[0] : 16'hDEAD), 32'd50);
        got_d.delete(); got_s.delete(); got_c.delete();
        push(8'd1, 8'd2, 16'd3, 1'b0);
        push(8'd2, 8'd2, 16'd2, 1'b1);
        push(8'd3, 8'd3, 16'd3, 1'b0);
        check("pre_rst_valid", 32'(u_if.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(u_if.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        push(8'd1, 8'd1, 16'h00FF, 1'b1);
        wait_results(1, "post_rst");
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_count", 32'(got_d.size()), 32'd1);
        check("post_rst_data", 32'((got_d.size() > 0) ? got_d[0] : 16'hDEAD), 32'd1);

        // Signed instance: -128*127, then accumulate twice (second one overflows)
        push_s(8'h80, 8'h7F, 16'd0, 1'b0);
        push_s(8'h80, 8'h7F, 16'hFFFF, 1'b1);
        push_s(8'h80, 8'h7F, 16'h7777, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("s_count", 32'(sgot_d.size()), 32'd3);
        check("s0_data", 32'((sgot_d.size() > 0) ? sgot_d[0] : 16'hDEAD), 32'h0000C080);
        check("s1_data", 32'((sgot_d.size() > 1) ? sgot_d[1] : 16'hDEAD), 32'h00008100);
        check("s1_sat", 32'((sgot_s.size() > 1) ? sgot_s[1] : 1'bx), 32'd0);
`ifdef MAC_SAT_EN
        check("s2_data", 32'((sgot_d.size() > 2) ? sgot_d[2] : 16'hDEAD), 32'h00008000);
        check("s2_sat", 32'((sgot_s.size() > 2) ? sgot_s[2] : 1'bx), 32'd1);
`else
        check("s2_data", 32'((sgot_d.size() > 2) ? sgot_d[2] : 16'hDEAD), 32'h00004180);
        check("s2_sat", 32'((sgot_s.size() > 2) ? sgot_s[2] : 1'bx), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
